// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings, FSM states and encoding check for the ALU scheduler
package alu_pkg;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0] func7;
        logic       err;
    } enc_t;

    // Immediate ops other than shifts carry no func7, so the field is forced
    // to base and can never make the op illegal.
    function automatic enc_t check_encoding(input logic [2:0] func3,
                                            input logic [6:0] func7,
                                            input logic       imm);
        enc_t r;
        logic normalized;
        normalized = imm && (func3 != F3_SLL) && (func3 != F3_SRL_SRA);
        r.func7 = normalized ? F7_BASE : func7;
        if (normalized) begin
            r.err = 1'b0;
        end else if ((func7 != F7_BASE) && (func7 != F7_ALT)) begin
            r.err = 1'b1;
        end else if ((func7 == F7_ALT) && (func3 != F3_ADD_SUB) && (func3 != F3_SRL_SRA)) begin
            r.err = 1'b1;
        end else begin
            r.err = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant memory updated on accept
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid_a,
    input  logic valid_b,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);

    logic last_grant;  // 0 = A, 1 = B

    always_comb begin
        grant_a = valid_a && (!valid_b || last_grant);
        grant_b = valid_b && (!valid_a || !last_grant);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_b;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler feeding the shared ALU and returning its result
module alu_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_a,
    input  logic             req_valid_b,
    output logic             req_ready_a,
    output logic             req_ready_b,
    input  logic [WIDTH-1:0] req_op1_a,
    input  logic [WIDTH-1:0] req_op1_b,
    input  logic [WIDTH-1:0] req_op2_a,
    input  logic [WIDTH-1:0] req_op2_b,
    input  logic [2:0]       req_func3_a,
    input  logic [2:0]       req_func3_b,
    input  logic [6:0]       req_func7_a,
    input  logic [6:0]       req_func7_b,
    input  logic             req_imm_a,
    input  logic             req_imm_b,
    output logic [WIDTH-1:0] alu_operand_1,
    output logic [WIDTH-1:0] alu_operand_2,
    output logic [2:0]       alu_op,
    output logic [6:0]       alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);
    import alu_pkg::*;

    state_t           state;
    logic             grant_a;
    logic             grant_b;
    logic             in_idle;
    logic             accept;
    logic             op_id;
    logic             op_err;
    logic [WIDTH-1:0] sel_op1;
    logic [WIDTH-1:0] sel_op2;
    logic [2:0]       sel_func3;
    logic [6:0]       sel_func7;
    logic             sel_imm;
    enc_t             enc;

    // Gating with rst keeps grants off while reset is held low.
    assign in_idle     = (state == ST_IDLE) && rst;
    assign req_ready_a = in_idle && grant_a;
    assign req_ready_b = in_idle && grant_b;
    assign accept      = req_ready_a || req_ready_b;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_a (req_valid_a),
        .valid_b (req_valid_b),
        .accept  (accept),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_comb begin
        sel_op1   = grant_b ? req_op1_b   : req_op1_a;
        sel_op2   = grant_b ? req_op2_b   : req_op2_a;
        sel_func3 = grant_b ? req_func3_b : req_func3_a;
        sel_func7 = grant_b ? req_func7_b : req_func7_a;
        sel_imm   = grant_b ? req_imm_b   : req_imm_a;
        enc       = check_encoding(sel_func3, sel_func7, sel_imm);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
            alu_op        <= F3_ADD_SUB;
            alu_op2       <= F7_BASE;
            op_id         <= 1'b0;
            op_err        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_data      <= '0;
            rsp_zero      <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_operand_1 <= sel_op1;
                        alu_operand_2 <= sel_op2;
                        alu_op        <= sel_func3;
                        alu_op2       <= enc.func7;
                        op_id         <= req_ready_b;
                        op_err        <= enc.err;
                        state         <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Illegal ops still run through the ALU but their result is discarded.
                    rsp_valid <= 1'b1;
                    rsp_id    <= op_id;
                    rsp_data  <= op_err ? '0 : alu_result;
                    rsp_zero  <= !op_err && alu_zero;
                    rsp_err   <= op_err;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched with a behavioural ALU
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic        req_ready_a, req_ready_b;
    logic [31:0] req_op1_a, req_op1_b, req_op2_a, req_op2_b;
    logic [2:0]  req_func3_a, req_func3_b;
    logic [6:0]  req_func7_a, req_func7_b;
    logic        req_imm_a, req_imm_b;
    logic [31:0] alu_operand_1, alu_operand_2;
    logic [2:0]  alu_op;
    logic [6:0]  alu_op2;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_sched #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
        .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
        .req_op1_a(req_op1_a), .req_op1_b(req_op1_b),
        .req_op2_a(req_op2_a), .req_op2_b(req_op2_b),
        .req_func3_a(req_func3_a), .req_func3_b(req_func3_b),
        .req_func7_a(req_func7_a), .req_func7_b(req_func7_b),
        .req_imm_a(req_imm_a), .req_imm_b(req_imm_b),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_op(alu_op), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = alu_op2[5] ? alu_operand_1 - alu_operand_2 : alu_operand_1 + alu_operand_2;
            3'b001: alu_result = alu_operand_1 << alu_operand_2[4:0];
            3'b010: alu_result = {31'd0, $signed(alu_operand_1) < $signed(alu_operand_2)};
            3'b011: alu_result = {31'd0, alu_operand_1 < alu_operand_2};
            3'b100: alu_result = alu_operand_1 ^ alu_operand_2;
            3'b101: alu_result = alu_op2[5] ? 32'($signed(alu_operand_1) >>> alu_operand_2[4:0])
                                            : alu_operand_1 >> alu_operand_2[4:0];
            3'b110: alu_result = alu_operand_1 | alu_operand_2;
            default: alu_result = alu_operand_1 & alu_operand_2;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid_a = 0; req_valid_b = 0;
        req_op1_a = 0; req_op2_a = 0; req_func3_a = 0; req_func7_a = 0; req_imm_a = 0;
        req_op1_b = 0; req_op2_b = 0; req_func3_b = 0; req_func7_b = 0; req_imm_b = 0;
    endtask

    task automatic drive(input logic is_b, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic imm);
        if (is_b) begin
            req_valid_b = 1; req_op1_b = op1; req_op2_b = op2;
            req_func3_b = f3; req_func7_b = f7; req_imm_b = imm;
        end else begin
            req_valid_a = 1; req_op1_a = op1; req_op2_a = op2;
            req_func3_a = f3; req_func7_a = f7; req_imm_a = imm;
        end
    endtask

    // One request from IDLE; hold keeps rsp_ready low that many cycles with both requesters pushing.
    task automatic run_one(input string tag, input logic is_b,
                           input logic [31:0] op1, input logic [31:0] op2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                           input logic [6:0] exp_op2, input logic [31:0] exp_data,
                           input logic exp_zero, input logic exp_err, input int hold);
        @(negedge clk);
        drive(is_b, op1, op2, f3, f7, imm);
        #1;
        check({tag, "_ready"}, {31'd0, is_b ? req_ready_b : req_ready_a}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        #1;
        check({tag, "_op1"}, alu_operand_1, op1);
        check({tag, "_func3"}, {29'd0, alu_op}, {29'd0, f3});
        check({tag, "_func7"}, {25'd0, alu_op2}, {25'd0, exp_op2});
        check({tag, "_early_valid"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, is_b});
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            drive(1'b0, 32'd1, 32'd1, 3'b000, 7'd0, 1'b0);
            drive(1'b1, 32'd2, 32'd2, 3'b000, 7'd0, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "_hold_data"}, rsp_data, exp_data);
            check({tag, "_hold_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
            check({tag, "_hold_ready"}, {30'd0, req_ready_a, req_ready_b}, 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        #1;
        check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
        if (hold > 0) begin
            // Requester A owned this op, so B takes the tie right after the handshake.
            check({tag, "_next_grant"}, {30'd0, req_ready_a, req_ready_b}, 32'd1);
            clear_reqs();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        rst = 0;
        rsp_ready = 0;
        clear_reqs();
        req_valid_a = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready_a", {31'd0, req_ready_a}, 32'd0);
        check("rst_op1", alu_operand_1, 32'd0);
        check("rst_func7", {25'd0, alu_op2}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_id_err", {30'd0, rsp_id, rsp_err}, 32'd0);
        req_valid_a = 0;
        rst = 1;

        run_one("add_a", 1'b0, 32'd5, 32'd7, 3'b000, 7'd0, 1'b0, 7'd0, 32'd12, 1'b0, 1'b0, 0);

        do_reset();
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 32'd1, 32'd2, 3'b000, 7'd0, 1'b0);
            drive(1'b1, 32'd10, 32'd20, 3'b000, 7'd0, 1'b0);
            #1;
            check("rr_grant", {30'd0, req_ready_a, req_ready_b}, (i % 2 == 0) ? 32'd2 : 32'd1);
            @(posedge clk);
            @(negedge clk);
            check("rr_exec_ready", {30'd0, req_ready_a, req_ready_b}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("rr_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_data", rsp_data, (i % 2 == 0) ? 32'd3 : 32'd30);
            @(posedge clk);
        end
        @(negedge clk);
        rsp_ready = 0;
        clear_reqs();

        run_one("imm_b", 1'b1, 32'd10, 32'd3, 3'b000, 7'b0100000, 1'b1, 7'd0, 32'd13, 1'b0, 1'b0, 0);
        run_one("ill_or", 1'b0, 32'd6, 32'd9, 3'b110, 7'b0100000, 1'b0, 7'b0100000, 32'd0, 1'b0, 1'b1, 0);
        run_one("ill_f7", 1'b0, 32'd6, 32'd9, 3'b000, 7'b1111111, 1'b0, 7'b1111111, 32'd0, 1'b0, 1'b1, 0);
        run_one("sub_hold", 1'b0, 32'd9, 32'd9, 3'b000, 7'b0100000, 1'b0, 7'b0100000, 32'd0, 1'b1, 1'b0, 4);

        // Reset in EXEC drops the op entirely.
        @(negedge clk);
        drive(1'b0, 32'd4, 32'd4, 3'b000, 7'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        req_valid_b = 1;
        rst = 0;
        #1;
        check("mid_rst_op1", alu_operand_1, 32'd0);
        check("mid_rst_op", {22'd0, alu_op2, alu_op}, 32'd0);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready_b}, 32'd0);
        @(negedge clk);
        rst = 1;
        req_valid_b = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid_a = 1;
        req_valid_b = 1;
        #1;
        check("mid_rst_tie", {30'd0, req_ready_a, req_ready_b}, 32'd2);
        clear_reqs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
